dpc_neighbor_collector: RTL

DPC_NEIGHBOR_COLLECTOR -- requirements
Module: dpc_neighbor_collector

---
 rtl/dpc_pkg.sv | 18 +
 rtl/dpc_popcount8.sv | 23 ++
 rtl/dpc_neighbor_collector.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dpc_pkg.sv
// rtl/dpc_pkg.sv - shared constants for the defective-pixel-correction neighbour path
package dpc_pkg;

   localparam int DPC_DATA_WIDTH = 16;
   localparam int NB_COUNT       = 8;
   localparam int DEST_WIDTH     = 3;

   // Raster order of the 3x3 window with the centre removed.
   localparam int NB_P00 = 0;
   localparam int NB_P01 = 1;
   localparam int NB_P02 = 2;
   localparam int NB_P10 = 3;
   localparam int NB_P12 = 4;
   localparam int NB_P20 = 5;
   localparam int NB_P21 = 6;
   localparam int NB_P22 = 7;

endpackage

// File: rtl/dpc_popcount8.sv
// rtl/dpc_popcount8.sv - 8-bit popcount plus per-index exclusive prefix counts
module dpc_popcount8
   import dpc_pkg::*;
(
   input  logic [7:0]  i_bits,
   output logic [3:0]  o_count,
   output logic [23:0] o_prefix
);

   logic [3:0] w_acc;

   // o_prefix[k] holds the number of set bits strictly below k.
   always_comb begin
      o_prefix = '0;
      w_acc    = '0;
      for (int k = 0; k < NB_COUNT; k++) begin
         o_prefix[k*DEST_WIDTH +: DEST_WIDTH] = w_acc[2:0];
         w_acc = w_acc + {3'b000, i_bits[k]};
      end
      o_count = w_acc;
   end

endmodule

// File: rtl/dpc_neighbor_collector.sv
// rtl/dpc_neighbor_collector.sv - compacts live 3x3 neighbours for the median stage and keeps frame statistics
module dpc_neighbor_collector
   import dpc_pkg::*;
#(
   parameter int DATA_WIDTH = DPC_DATA_WIDTH,
   parameter int CNT_WIDTH  = 20
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_in,
   input  logic                  sof,
   input  logic [DATA_WIDTH-1:0] nb0,
   input  logic [DATA_WIDTH-1:0] nb1,
   input  logic [DATA_WIDTH-1:0] nb2,
   input  logic [DATA_WIDTH-1:0] nb3,
   input  logic [DATA_WIDTH-1:0] nb4,
   input  logic [DATA_WIDTH-1:0] nb5,
   input  logic [DATA_WIDTH-1:0] nb6,
   input  logic [DATA_WIDTH-1:0] nb7,
   input  logic [7:0]            nb_dead,
   input  logic [DATA_WIDTH-1:0] center_in,
   input  logic                  center_dead_in,
   output logic                  valid_out,
   output logic [DATA_WIDTH-1:0] data0,
   output logic [DATA_WIDTH-1:0] data1,
   output logic [DATA_WIDTH-1:0] data2,
   output logic [DATA_WIDTH-1:0] data3,
   output logic [DATA_WIDTH-1:0] data4,
   output logic [DATA_WIDTH-1:0] data5,
   output logic [DATA_WIDTH-1:0] data6,
   output logic [DATA_WIDTH-1:0] data7,
   output logic [3:0]            valid_count,
   output logic [DATA_WIDTH-1:0] center_out,
   output logic                  center_dead_out,
   output logic [CNT_WIDTH-1:0]  dead_cnt,
   output logic [CNT_WIDTH-1:0]  empty_cnt
);

   logic [DATA_WIDTH-1:0] w_nb [NB_COUNT];
   logic [7:0]            w_live;
   logic [3:0]            w_live_cnt;
   logic [23:0]           w_prefix;

   logic                  r1_valid;
   logic [DATA_WIDTH-1:0] r1_nb [NB_COUNT];
   logic [DEST_WIDTH-1:0] r1_dest [NB_COUNT];
   logic [7:0]            r1_live;
   logic [DATA_WIDTH-1:0] r1_center;
   logic                  r1_center_dead;

   logic [DATA_WIDTH-1:0] w_comp [NB_COUNT];
   logic [3:0]            w_cnt;

   logic                  r2_valid;
   logic [DATA_WIDTH-1:0] r2_data [NB_COUNT];
   logic [3:0]            r2_count;
   logic [DATA_WIDTH-1:0] r2_center;
   logic                  r2_center_dead;

   logic                  w_inc_dead;
   logic                  w_inc_empty;
   logic [CNT_WIDTH-1:0]  r_run_dead;
   logic [CNT_WIDTH-1:0]  r_run_empty;
   logic [CNT_WIDTH-1:0]  r_dead_cnt;
   logic [CNT_WIDTH-1:0]  r_empty_cnt;

   assign w_nb[NB_P00] = nb0;
   assign w_nb[NB_P01] = nb1;
   assign w_nb[NB_P02] = nb2;
   assign w_nb[NB_P10] = nb3;
   assign w_nb[NB_P12] = nb4;
   assign w_nb[NB_P20] = nb5;
   assign w_nb[NB_P21] = nb6;
   assign w_nb[NB_P22] = nb7;
   assign w_live       = ~nb_dead;

   dpc_popcount8 u_popcount (
      .i_bits   (w_live),
      .o_count  (w_live_cnt),
      .o_prefix (w_prefix)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_valid       <= 1'b0;
         r1_live        <= '0;
         r1_center      <= '0;
         r1_center_dead <= 1'b0;
         for (int k = 0; k < NB_COUNT; k++) begin
            r1_nb[k]   <= '0;
            r1_dest[k] <= '0;
         end
      end else begin
         r1_valid <= valid_in;
         if (valid_in) begin
            r1_live        <= w_live;
            r1_center      <= center_in;
            r1_center_dead <= center_dead_in;
            for (int k = 0; k < NB_COUNT; k++) begin
               r1_nb[k]   <= w_nb[k];
               r1_dest[k] <= w_prefix[k*DEST_WIDTH +: DEST_WIDTH];
            end
         end
      end
   end

   // Scatter each live pixel to its prefix slot; untouched slots stay zero.
   always_comb begin
      for (int j = 0; j < NB_COUNT; j++) begin
         w_comp[j] = '0;
      end
      for (int k = 0; k < NB_COUNT; k++) begin
         if (r1_live[k]) begin
            w_comp[r1_dest[k]] = r1_nb[k];
         end
      end
   end

   assign w_cnt = {1'b0, r1_dest[NB_COUNT-1]} + {3'b000, r1_live[NB_COUNT-1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r2_valid       <= 1'b0;
         r2_count       <= '0;
         r2_center      <= '0;
         r2_center_dead <= 1'b0;
         for (int k = 0; k < NB_COUNT; k++) begin
            r2_data[k] <= '0;
         end
      end else begin
         r2_valid <= r1_valid;
         if (r1_valid) begin
            r2_count       <= w_cnt;
            r2_center      <= r1_center;
            r2_center_dead <= r1_center_dead;
            for (int k = 0; k < NB_COUNT; k++) begin
               r2_data[k] <= w_comp[k];
            end
         end
      end
   end

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic inc);
      return (inc && !(&v)) ? v + CNT_WIDTH'(1) : v;
   endfunction

   assign w_inc_dead  = valid_in & center_dead_in;
   assign w_inc_empty = valid_in & (w_live_cnt == 4'd0);

   // A pixel arriving with sof belongs to the new frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run_dead  <= '0;
         r_run_empty <= '0;
         r_dead_cnt  <= '0;
         r_empty_cnt <= '0;
      end else if (sof) begin
         r_dead_cnt  <= r_run_dead;
         r_empty_cnt <= r_run_empty;
         r_run_dead  <= CNT_WIDTH'(w_inc_dead);
         r_run_empty <= CNT_WIDTH'(w_inc_empty);
      end else begin
         r_run_dead  <= sat_inc(r_run_dead, w_inc_dead);
         r_run_empty <= sat_inc(r_run_empty, w_inc_empty);
      end
   end

   assign valid_out       = r2_valid;
   assign data0           = r2_data[0];
   assign data1           = r2_data[1];
   assign data2           = r2_data[2];
   assign data3           = r2_data[3];
   assign data4           = r2_data[4];
   assign data5           = r2_data[5];
   assign data6           = r2_data[6];
   assign data7           = r2_data[7];
   assign valid_count     = r2_count;
   assign center_out      = r2_center;
   assign center_dead_out = r2_center_dead;
   assign dead_cnt        = r_dead_cnt;
   assign empty_cnt       = r_empty_cnt;

endmodule
